fp8_div_seq: RTL and testbench

Sequential divider for the 8-bit minifloat format used by the accelerator's multiplier: 1 sign, 3 exponent and 4 mantissa bits, bias 3. It is the inverse arithmetic unit and serves normalisation and gating paths in the LSTM datapath. It computes a/b with a radix-2 restoring iteration behind a valid/ready handshake. A mode bit selects unsigned 8-bit integer division instead.

---
 rtl/fp8_pkg.sv | 29 ++
 rtl/fp8_unpack.sv | 45 ++++
 rtl/fp8_div_seq.sv | 166 ++++++++++++++++
 tb/tb_fp8_div_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// Shared types and constants for the 8-bit minifloat divider.
// Format: 1 sign, EXP_W exponent, MANT_W mantissa bits, biased by BIAS.
package fp8_pkg;

  localparam int EXP_W  = 3;
  localparam int MANT_W = 4;
  localparam int BIAS   = 3;
  localparam int W      = 1 + EXP_W + MANT_W;
  localparam int SIG_W  = MANT_W + 1;

  localparam logic [W-1:0] FP8_ZERO    = 8'h00;
  localparam logic [W-2:0] FP8_MAX_MAG = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_NORM,
    S_DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic signed [5:0] exp;
    logic [SIG_W-1:0]  sig;
    logic              is_zero;
  } fp8_unp_t;

endpackage

// File: rtl/fp8_unpack.sv
// Combinational operand unpack: field split, zero detect, denormal
// normalisation. Ports: i_op (packed operand), o_unp (unpacked fields).
module fp8_unpack
  import fp8_pkg::*;
(
  input  logic [W-1:0] i_op,
  output fp8_unp_t     o_unp
);

  logic [2:0] w_e;
  logic [3:0] w_m;

  assign w_e = i_op[6:4];
  assign w_m = i_op[3:0];

  always_comb begin
    o_unp.sign    = i_op[7];
    o_unp.is_zero = (w_e == 3'd0) && (w_m == 4'd0);
    o_unp.exp     = $signed({3'b000, w_e});
    o_unp.sig     = {1'b1, w_m};
    if (w_e == 3'd0) begin
      // Denormal: shift the leading one up to the hidden-bit
      // position; exponent becomes 1 - shift.
      casez (w_m)
        4'b1???: begin
          o_unp.sig = {w_m, 1'b0};
          o_unp.exp = 6'sd0;
        end
        4'b01??: begin
          o_unp.sig = {w_m[2:0], 2'b00};
          o_unp.exp = -6'sd1;
        end
        4'b001?: begin
          o_unp.sig = {w_m[1:0], 3'b000};
          o_unp.exp = -6'sd2;
        end
        default: begin
          o_unp.sig = 5'b10000;
          o_unp.exp = -6'sd3;
        end
      endcase
    end
  end

endmodule

// File: rtl/fp8_div_seq.sv
// Sequential restoring divider: minifloat (mode=0) or unsigned int (mode=1).
// Ports: clk/rst, in_valid/in_ready/in_a/in_b/mode, out_valid/out_ready/res/div_by_zero.
module fp8_div_seq
  import fp8_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         div_by_zero
);

  state_t r_state, w_next;

  logic [7:0] r_a, r_b;
  logic       r_mode;
  logic       r_sign;
  logic signed [5:0] r_ea, r_eb;
  logic [4:0] r_sb;
  logic [8:0] r_rem;
  logic [7:0] r_q;
  logic [3:0] r_cnt;
  logic       r_special;
  logic [7:0] r_res;
  logic       r_dz;

  fp8_unp_t w_ua, w_ub;

  fp8_unpack u_unp_a (.i_op(r_a), .o_unp(w_ua));
  fp8_unpack u_unp_b (.i_op(r_b), .o_unp(w_ub));

  logic       w_special, w_sp_dz;
  logic [7:0] w_sp_res;

  always_comb begin
    w_special = 1'b0;
    w_sp_dz   = 1'b0;
    w_sp_res  = FP8_ZERO;
    if (r_mode) begin
      if (r_b == 8'd0) begin
        w_special = 1'b1;
        w_sp_dz   = 1'b1;
        w_sp_res  = 8'hFF;
      end
    end else if (w_ub.is_zero) begin
      w_special = 1'b1;
      w_sp_dz   = 1'b1;
      if (!w_ua.is_zero)
        w_sp_res = {w_ua.sign ^ w_ub.sign, FP8_MAX_MAG};
    end else if (w_ua.is_zero) begin
      w_special = 1'b1;
    end
  end

  // Integer mode shifts dividend bits in from r_q; FP mode keeps the
  // partial remainder in r_rem and shifts it after each trial.
  logic [8:0] w_div, w_part, w_trial, w_keep;
  logic       w_ok;
  logic [3:0] w_last;

  assign w_div   = r_mode ? {1'b0, r_b} : {4'b0000, r_sb};
  assign w_part  = r_mode ? {r_rem[7:0], r_q[7]} : r_rem;
  assign w_trial = w_part - w_div;
  assign w_ok    = ~w_trial[8];
  assign w_keep  = w_ok ? w_trial : w_part;
  assign w_last  = r_mode ? 4'd7 : 4'd5;

  logic signed [5:0] w_qe, w_qe2;
  logic [4:0] w_sig;
  logic [5:0] w_sh;
  logic [3:0] w_den;
  logic [7:0] w_norm;

  always_comb begin
    w_qe  = r_ea - r_eb + $signed(6'(BIAS));
    w_qe2 = r_q[5] ? w_qe : w_qe - 6'sd1;
    w_sig = r_q[5] ? r_q[5:1] : r_q[4:0];
    w_sh  = 6'sd1 - w_qe2;
    w_den = 4'(w_sig >> w_sh);
    w_norm = FP8_ZERO;
    if (w_qe2 > 6'sd7)
      w_norm = {r_sign, FP8_MAX_MAG};
    else if (w_qe2 >= 6'sd1)
      w_norm = {r_sign, w_qe2[2:0], w_sig[3:0]};
    else if (w_den != 4'd0)
      w_norm = {r_sign, 3'b000, w_den};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_next = S_PREP;
      // Specials bypass the iteration but still pass through NORM,
      // which is the single point where results become visible.
      S_PREP: w_next = w_special ? S_NORM : S_DIV;
      S_DIV:  if (r_cnt == w_last) w_next = S_NORM;
      S_NORM: w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_mode    <= 1'b0;
      r_sign    <= 1'b0;
      r_ea      <= '0;
      r_eb      <= '0;
      r_sb      <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_special <= 1'b0;
      r_res     <= FP8_ZERO;
      r_dz      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (in_valid) begin
          r_a    <= in_a;
          r_b    <= in_b;
          r_mode <= mode;
        end
        S_PREP: begin
          r_sign    <= w_ua.sign ^ w_ub.sign;
          r_ea      <= w_ua.exp;
          r_eb      <= w_ub.exp;
          r_sb      <= w_ub.sig;
          r_rem     <= r_mode ? 9'd0 : {4'b0000, w_ua.sig};
          r_q       <= r_mode ? r_a : 8'd0;
          r_cnt     <= '0;
          r_special <= w_special;
          r_dz      <= w_sp_dz;
          if (w_special) r_res <= w_sp_res;
        end
        S_DIV: begin
          r_rem <= r_mode ? w_keep : {w_keep[7:0], 1'b0};
          r_q   <= {r_q[6:0], w_ok};
          r_cnt <= r_cnt + 4'd1;
        end
        S_NORM: if (!r_special) begin
          r_res <= r_mode ? r_q : w_norm;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign res         = r_res;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_fp8_div_seq.sv
// Self-checking bench for fp8_div_seq: directed ops, scoreboard queue,
// latency, handshake hold, busy-time input and mid-op reset.
module tb_fp8_div_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] res;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] res;
    logic       dz;
    int         lat;
  } exp_t;

  exp_t sb_q[$];

  fp8_div_seq dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .mode(mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res(res),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic [7:0] er,
                        input logic edz, input int elat,
                        input int hold, input bit poke);
    exp_t e;
    int n;
    logic [7:0] r0;
    e.res = er;
    e.dz  = edz;
    e.lat = elat;
    sb_q.push_back(e);
    @(negedge clk);
    in_a = a;
    in_b = b;
    mode = m;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 40 && !out_valid) begin
      @(posedge clk);
      #1;
      n++;
      if (poke && n == 2) begin
        in_valid = 1'b1;
        in_a = 8'h7F;
        in_b = 8'h01;
        mode = 1'b1;
      end
      if (poke && n == 3) in_valid = 1'b0;
    end
    chk("out_valid", out_valid, 1);
    e = sb_q.pop_front();
    chk("latency", n, e.lat);
    chk("res", res, e.res);
    chk("dz", div_by_zero, e.dz);
    r0 = res;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_res", res, r0);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_fall", out_valid, 0);
    chk("in_ready_rise", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    mode = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_dz", div_by_zero, 0);
    rst = 1'b0;

    run_op(8'h48, 8'h40, 1'b0, 8'h38, 1'b0, 8, 0, 1'b0);
    run_op(8'h30, 8'h48, 1'b0, 8'h15, 1'b0, 8, 0, 1'b0);
    run_op(8'hB0, 8'h40, 1'b0, 8'hA0, 1'b0, 8, 0, 1'b0);
    run_op(8'h7F, 8'h20, 1'b0, 8'h7F, 1'b0, 8, 0, 1'b0);
    run_op(8'hFF, 8'h20, 1'b0, 8'hFF, 1'b0, 8, 0, 1'b0);
    run_op(8'h10, 8'h40, 1'b0, 8'h08, 1'b0, 8, 0, 1'b0);
    run_op(8'h10, 8'h7F, 1'b0, 8'h00, 1'b0, 8, 0, 1'b0);
    run_op(8'h30, 8'h00, 1'b0, 8'h7F, 1'b1, 2, 0, 1'b0);
    run_op(8'hB0, 8'h00, 1'b0, 8'hFF, 1'b1, 2, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 2, 0, 1'b0);
    run_op(8'h80, 8'h30, 1'b0, 8'h00, 1'b0, 2, 0, 1'b0);
    run_op(8'hC8, 8'h07, 1'b1, 8'h1C, 1'b0, 10, 0, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1, 8'hFF, 1'b1, 2, 0, 1'b0);
    run_op(8'h48, 8'h40, 1'b0, 8'h38, 1'b0, 8, 5, 1'b1);
    @(posedge clk);
    #1;
    chk("no_ghost_op", out_valid, 0);

    @(negedge clk);
    in_a = 8'h48;
    in_b = 8'h40;
    mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_res", res, 0);
    chk("midrst_dz", div_by_zero, 0);

    run_op(8'h30, 8'h48, 1'b0, 8'h15, 1'b0, 8, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
